// File: rtl/comb_lock_pkg.sv
// Shared types and helpers for the combination lock controller.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    UNLOCKED = 3'd2,
    PROGRAM  = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // Helpers operate on a zero-extended button vector so they are independent of NUM_BTN.
  localparam int unsigned MAX_BTN   = 32;
  localparam int unsigned BTN_IDX_W = 5;

  // A press is a valid digit only when exactly one button bit is set.
  function automatic logic valid_press(input logic [MAX_BTN-1:0] vec);
    return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit if not one-hot).
  function automatic logic [BTN_IDX_W-1:0] onehot_to_idx(input logic [MAX_BTN-1:0] vec);
    logic [BTN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_BTN; i++) begin
      idx = vec[i] ? BTN_IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // Largest of three cycle counts; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared loadable down-counter. expired flags the cycle in which the count steps to zero.
module lock_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_r;

  // Down-count saturating at zero; a load takes priority over the decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == ONE);

endmodule

// File: rtl/comb_lock_ctrl.sv
// Sequencing FSM of the combination lock: digit entry, unlock window, lockout and
// code reprogramming. All outputs are registered from the next-state values.
module comb_lock_ctrl
  import comb_lock_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned CODE_LEN    = 4,
  parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] DEFAULT_CODE = 8'hE4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned TIMEOUT_CYC = 500,
  parameter int unsigned UNLOCK_CYC  = 200,
  parameter int unsigned LOCKOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BTN-1:0]            btn_pulse,
  input  logic                          prog_en,
  output logic                          unlock,
  output logic                          lockout,
  output logic                          err,
  output logic                          prog_busy,
  output logic [$clog2(CODE_LEN+1)-1:0] digit_cnt
);

  localparam int unsigned DIG_W  = $clog2(NUM_BTN);
  localparam int unsigned CODE_W = CODE_LEN * DIG_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_W  = $clog2(max3(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC) + 1);

  localparam logic [CNT_W-1:0]  LAST_DIG  = CNT_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [FAIL_W-1:0] LAST_FAIL = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);
  localparam logic [TMR_W-1:0]  T_TIMEOUT = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]  T_UNLOCK  = TMR_W'(UNLOCK_CYC);
  localparam logic [TMR_W-1:0]  T_LOCKOUT = TMR_W'(LOCKOUT_CYC);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    digit_cnt_r, digit_cnt_s;
  logic                mismatch_r, mismatch_s;
  logic [FAIL_W-1:0]   fail_cnt_r, fail_cnt_s;
  logic [CODE_W-1:0]   code_reg_r, code_reg_s;
  logic [CODE_W-1:0]   shadow_r, shadow_s;
  logic                err_s;
  logic                tmr_load_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic                tmr_expired_s;

  logic                unlock_r, lockout_r, err_r, prog_busy_r;

  logic [MAX_BTN-1:0]  btn_ext_s;
  logic                press_s;
  logic                valid_s;
  logic [DIG_W-1:0]    digit_s;
  logic [CNT_W-1:0]    base_cnt_s;
  logic                base_mis_s;
  logic [DIG_W-1:0]    code_dig_s;
  logic                attempt_mis_s;
  logic [CODE_W-1:0]   prog_code_s;

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // Decode the press and compare it against the code digit at the current position.
  always_comb begin
    btn_ext_s = '0;
    btn_ext_s[NUM_BTN-1:0] = btn_pulse;
    press_s    = (btn_pulse != '0);
    valid_s    = valid_press(btn_ext_s);
    digit_s    = DIG_W'(onehot_to_idx(btn_ext_s));
    // The press that leaves IDLE is digit 0 of a fresh attempt.
    base_cnt_s = (state_r == ENTRY) ? digit_cnt_r : '0;
    base_mis_s = (state_r == ENTRY) ? mismatch_r : 1'b0;
    code_dig_s = '0;
    prog_code_s = shadow_r;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      code_dig_s = (base_cnt_s == CNT_W'(i)) ? code_reg_r[i*DIG_W +: DIG_W] : code_dig_s;
      prog_code_s[i*DIG_W +: DIG_W] = (digit_cnt_r == CNT_W'(i)) ? digit_s
                                                                : shadow_r[i*DIG_W +: DIG_W];
    end
    // An invalid (multi-button) press never matches any code digit.
    attempt_mis_s = base_mis_s || !valid_s || (digit_s != code_dig_s);
  end

  // Next-state, datapath updates and timer control.
  always_comb begin
    state_s     = state_r;
    digit_cnt_s = digit_cnt_r;
    mismatch_s  = mismatch_r;
    fail_cnt_s  = fail_cnt_r;
    code_reg_s  = code_reg_r;
    shadow_s    = shadow_r;
    err_s       = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;
    case (state_r)
      IDLE, ENTRY: begin
        if (press_s) begin
          if (base_cnt_s == LAST_DIG) begin
            digit_cnt_s = '0;
            mismatch_s  = 1'b0;
            if (!attempt_mis_s) begin
              state_s    = UNLOCKED;
              fail_cnt_s = '0;
              tmr_load_s = 1'b1;
              tmr_val_s  = T_UNLOCK;
            end else begin
              err_s = 1'b1;
              if (fail_cnt_r == LAST_FAIL) begin
                state_s    = LOCKOUT;
                fail_cnt_s = '0;
                tmr_load_s = 1'b1;
                tmr_val_s  = T_LOCKOUT;
              end else begin
                state_s    = IDLE;
                fail_cnt_s = fail_cnt_r + FAIL_ONE;
              end
            end
          end else begin
            state_s     = ENTRY;
            digit_cnt_s = base_cnt_s + CNT_ONE;
            mismatch_s  = attempt_mis_s;
            tmr_load_s  = 1'b1;
            tmr_val_s   = T_TIMEOUT;
          end
        end else if ((state_r == ENTRY) && tmr_expired_s) begin
          // Abandoned attempt: discard digits quietly, failure count untouched.
          state_s     = IDLE;
          digit_cnt_s = '0;
          mismatch_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      UNLOCKED: begin
        if (prog_en) begin
          state_s     = PROGRAM;
          digit_cnt_s = '0;
          tmr_load_s  = 1'b1;
          tmr_val_s   = T_TIMEOUT;
        end else if (tmr_expired_s) begin
          state_s     = IDLE;
          digit_cnt_s = '0;
        end else begin
          state_s = UNLOCKED;
        end
      end
      PROGRAM: begin
        if (press_s) begin
          if (!valid_s) begin
            err_s       = 1'b1;
            state_s     = IDLE;
            digit_cnt_s = '0;
          end else if (digit_cnt_r == LAST_DIG) begin
            code_reg_s  = prog_code_s;
            state_s     = IDLE;
            digit_cnt_s = '0;
          end else begin
            shadow_s    = prog_code_s;
            digit_cnt_s = digit_cnt_r + CNT_ONE;
            tmr_load_s  = 1'b1;
            tmr_val_s   = T_TIMEOUT;
          end
        end else if (tmr_expired_s) begin
          state_s     = IDLE;
          digit_cnt_s = '0;
        end else begin
          state_s = PROGRAM;
        end
      end
      LOCKOUT: begin
        if (tmr_expired_s) begin
          state_s     = IDLE;
          digit_cnt_s = '0;
        end else begin
          state_s = LOCKOUT;
        end
      end
      default: begin
        state_s     = IDLE;
        digit_cnt_s = '0;
        mismatch_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset restores the default code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      digit_cnt_r <= '0;
      mismatch_r  <= 1'b0;
      fail_cnt_r  <= '0;
      code_reg_r  <= DEFAULT_CODE;
      shadow_r    <= '0;
    end else begin
      state_r     <= state_s;
      digit_cnt_r <= digit_cnt_s;
      mismatch_r  <= mismatch_s;
      fail_cnt_r  <= fail_cnt_s;
      code_reg_r  <= code_reg_s;
      shadow_r    <= shadow_s;
    end
  end

  // Registered status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      unlock_r    <= 1'b0;
      lockout_r   <= 1'b0;
      err_r       <= 1'b0;
      prog_busy_r <= 1'b0;
    end else begin
      unlock_r    <= (state_s == UNLOCKED);
      lockout_r   <= (state_s == LOCKOUT);
      err_r       <= err_s;
      prog_busy_r <= (state_s == PROGRAM);
    end
  end

  assign unlock    = unlock_r;
  assign lockout   = lockout_r;
  assign err       = err_r;
  assign prog_busy = prog_busy_r;
  assign digit_cnt = digit_cnt_r;

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Scoreboard bench for comb_lock_ctrl (short timers, default code 0,1,2,3).
module tb_comb_lock_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_pulse;
  logic       prog_en;
  logic       unlock;
  logic       lockout;
  logic       err;
  logic       prog_busy;
  logic [2:0] digit_cnt;

  int checks   = 0;
  int failures = 0;

  // Expected output vector {unlock, lockout, err, prog_busy, digit_cnt[2:0]}.
  localparam logic [6:0] E_ZERO   = 7'b000_0000;
  localparam logic [6:0] E_C1     = 7'b000_0001;
  localparam logic [6:0] E_C2     = 7'b000_0010;
  localparam logic [6:0] E_C3     = 7'b000_0011;
  localparam logic [6:0] E_UNL    = 7'b100_0000;
  localparam logic [6:0] E_ERR    = 7'b001_0000;
  localparam logic [6:0] E_LCK    = 7'b010_0000;
  localparam logic [6:0] E_LCKERR = 7'b011_0000;
  localparam logic [6:0] E_PB0    = 7'b000_1000;
  localparam logic [6:0] E_PB1    = 7'b000_1001;
  localparam logic [6:0] E_PB2    = 7'b000_1010;
  localparam logic [6:0] E_PB3    = 7'b000_1011;

  localparam logic [3:0] B0  = 4'b0001;
  localparam logic [3:0] B1  = 4'b0010;
  localparam logic [3:0] B2  = 4'b0100;
  localparam logic [3:0] B3  = 4'b1000;
  localparam logic [3:0] BX  = 4'b0011;
  localparam logic [3:0] BN  = 4'b0000;

  typedef struct packed {
    logic [3:0] btn;
    logic       prog;
    logic       rst;
    logic [6:0] exp;
  } step_t;

  step_t      stim_q[$];
  logic [6:0] sb_q[$];

  comb_lock_ctrl #(
    .NUM_BTN     (4),
    .CODE_LEN    (4),
    .DEFAULT_CODE(8'hE4),
    .MAX_FAIL    (3),
    .TIMEOUT_CYC (8),
    .UNLOCK_CYC  (6),
    .LOCKOUT_CYC (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .prog_en   (prog_en),
    .unlock    (unlock),
    .lockout   (lockout),
    .err       (err),
    .prog_busy (prog_busy),
    .digit_cnt (digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic [3:0] b, input logic p, input logic r, input logic [6:0] e);
    step_t st;
    st.btn  = b;
    st.prog = p;
    st.rst  = r;
    st.exp  = e;
    stim_q.push_back(st);
  endtask

  task automatic add_idle(input int n, input logic [6:0] e);
    for (int i = 0; i < n; i++) add(BN, 1'b0, 1'b0, e);
  endtask

  task automatic add_code(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                          input logic [3:0] b3, input logic [6:0] last);
    add(b0, 1'b0, 1'b0, E_C1);
    add(b1, 1'b0, 1'b0, E_C2);
    add(b2, 1'b0, 1'b0, E_C3);
    add(b3, 1'b0, 1'b0, last);
  endtask

  task automatic test_reset();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add(BN, 1'b0, 1'b1, E_ZERO);
    add(BN, 1'b0, 1'b1, E_ZERO);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL reset step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_unlock();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add_code(B0, B1, B2, B3, E_UNL);
    add(B0, 1'b0, 1'b0, E_UNL);
    add_idle(4, E_UNL);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL unlock step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_lockout();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add_code(B0, B1, B2, B2, E_ERR);
    add_idle(1, E_ZERO);
    add_code(B0, B1, B2, B2, E_ERR);
    add_code(B0, B1, B2, B2, E_LCKERR);
    for (int i = 0; i < 9; i++) add(((i % 2) == 0) ? B0 : BX, 1'b0, 1'b0, E_LCK);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL lockout step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add_code(B0, B1, B2, B2, E_ERR);
    add_code(B0, B1, B2, B2, E_ERR);
    add(B0, 1'b0, 1'b0, E_C1);
    add(B1, 1'b0, 1'b0, E_C2);
    add_idle(7, E_C2);
    add_idle(1, E_ZERO);
    add_code(B0, B1, B2, B2, E_LCKERR);
    add_idle(9, E_LCK);
    add_idle(1, E_ZERO);
    add_code(B0, B1, B2, B3, E_UNL);
    add_idle(5, E_UNL);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL timeout step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_invalid();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add_code(B0, BX, B2, B3, E_ERR);
    add_idle(1, E_ZERO);
    add_code(B0, B1, B2, B3, E_UNL);
    add_idle(5, E_UNL);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL invalid step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_program();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add_code(B0, B1, B2, B3, E_UNL);
    add(BN, 1'b1, 1'b0, E_PB0);
    add(B3, 1'b0, 1'b0, E_PB1);
    add(B3, 1'b0, 1'b0, E_PB2);
    add(B1, 1'b0, 1'b0, E_PB3);
    add(B0, 1'b0, 1'b0, E_ZERO);
    add_code(B0, B1, B2, B3, E_ERR);
    add_code(B3, B3, B1, B0, E_UNL);
    add(BN, 1'b1, 1'b0, E_PB0);
    add(BX, 1'b0, 1'b0, E_ERR);
    add_idle(1, E_ZERO);
    add_code(B3, B3, B1, B0, E_UNL);
    add_idle(5, E_UNL);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL program step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    step_t st; logic [6:0] ev, gv; int n = 0;
    add(B3, 1'b0, 1'b0, E_C1);
    add(B3, 1'b0, 1'b0, E_C2);
    add(BN, 1'b0, 1'b1, E_ZERO);
    add_code(B0, B1, B2, B3, E_UNL);
    add(BN, 1'b1, 1'b0, E_PB0);
    add(B3, 1'b0, 1'b0, E_PB1);
    add(BN, 1'b0, 1'b1, E_ZERO);
    add_code(B0, B1, B2, B3, E_UNL);
    add_idle(5, E_UNL);
    add_idle(1, E_ZERO);
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      btn_pulse = st.btn; prog_en = st.prog; reset = st.rst;
      sb_q.push_back(st.exp);
      @(negedge clk);
      ev = sb_q.pop_front();
      gv = {unlock, lockout, err, prog_busy, digit_cnt};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL reset_mid step %0d: got %b required %b", n, gv, ev);
      end
      n++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_pulse = 4'b0000;
    prog_en   = 1'b0;
    @(negedge clk);
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_invalid();
    test_program();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
